// File: rtl/five_way_rr_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// five_way_rr_scheduler_pkg
//   Shared definitions for the five-way round-robin scheduler:
//     NUM_REQ        requester count (fixed at 5)
//     id_t           3-bit requester index
//     state_t        scheduler FSM states IDLE / GRANT / GAP
//     LAST_ID_RESET  reset value of the round-robin pointer, chosen so the
//                    first scan after reset starts at index 0
//     id_to_onehot   index -> one-hot grant vector
// -----------------------------------------------------------------------------
package five_way_rr_scheduler_pkg;

  localparam int unsigned NUM_REQ = 5;
  localparam int unsigned ID_W    = 3;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam id_t LAST_ID_RESET = id_t'(NUM_REQ - 1);

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input id_t id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/five_way_rr_scheduler_rr_pick5.sv
// -----------------------------------------------------------------------------
// rr_pick5
//   Combinational round-robin picker over five requesters. The scan visits
//   last_id+1, last_id+2, ... modulo 5, so the previous winner is examined
//   last and therefore has the lowest priority.
//
//   Ports
//     i_elig     [4:0]  eligible vector (request AND enable)
//     i_last_id  [2:0]  index of the most recent winner
//     o_found           at least one eligible requester exists
//     o_winner   [2:0]  index of the selected requester (0 when !o_found)
// -----------------------------------------------------------------------------
module rr_pick5
  import five_way_rr_scheduler_pkg::*;
(
  input  logic [4:0] i_elig,
  input  logic [2:0] i_last_id,
  output logic       o_found,
  output logic [2:0] o_winner
);

  int unsigned w_base;
  int unsigned w_sum;
  logic [2:0]  w_idx;

  always_comb begin
    o_found  = 1'b0;
    o_winner = '0;
    w_base   = {29'd0, i_last_id};
    w_sum    = 0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_sum = w_base + k;
      w_idx = 3'(w_sum % NUM_REQ);
      // First hit in scan order wins; later hits are ignored.
      if (!o_found && i_elig[w_idx]) begin
        o_found  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/five_way_rr_scheduler.sv
// -----------------------------------------------------------------------------
// five_way_rr_scheduler
//   Five-requester round-robin scheduler with bounded grant tenure.
//   A grant lasts 1..MAX_HOLD cycles and is followed by exactly one gap cycle
//   with no grant. A tenure ends on owner release, owner dropping its request,
//   owner disabled by en_mask, or reaching MAX_HOLD cycles. Only the last case
//   is a forced revocation, flagged by timeout_pulse and counted in
//   timeout_cnt (saturating at 255).
//
//   Parameters
//     MAX_HOLD  maximum consecutive grant cycles per tenure (1..255)
//     NUM_REQ   requester count, fixed at 5
//
//   Ports
//     clk            clock, rising edge
//     rst_n          asynchronous active-low reset
//     req      [4:0] request levels
//     release_i[4:0] end-of-use pulses (only the owner's bit is honoured)
//     en_mask  [4:0] per-requester enable
//     gnt      [4:0] one-hot grant (registered)
//     gnt_valid      OR of gnt (registered)
//     gnt_id   [2:0] current/last owner index (registered)
//     timeout_pulse  one-cycle flag in the gap after a forced revocation
//     timeout_cnt[7:0] saturating forced-revocation count
// -----------------------------------------------------------------------------
module five_way_rr_scheduler
  import five_way_rr_scheduler_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned NUM_REQ  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] release_i,
  input  logic [NUM_REQ-1:0] en_mask,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [2:0]         gnt_id,
  output logic               timeout_pulse,
  output logic [7:0]         timeout_cnt
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_gnt_valid;
  id_t                r_gnt_id;
  id_t                r_last_id;
  logic [7:0]         r_hold_cnt;
  logic               r_timeout_pulse;
  logic [7:0]         r_timeout_cnt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  id_t                w_winner;
  logic               w_own_release;
  logic               w_own_drop;
  logic               w_own_disabled;
  logic               w_hold_limit;
  logic               w_exit;
  logic               w_timeout;

  assign w_elig = req & en_mask;

  rr_pick5 u_pick (
    .i_elig    (w_elig),
    .i_last_id (r_last_id),
    .o_found   (w_found),
    .o_winner  (w_winner)
  );

  // Masking with the one-hot grant selects the owner's bit; non-owner
  // release bits fall out naturally, and outside GRANT r_gnt is zero.
  assign w_own_release  = |(release_i & r_gnt);
  assign w_own_drop     = |(~req & r_gnt);
  assign w_own_disabled = |(~en_mask & r_gnt);
  assign w_hold_limit   = (r_hold_cnt == HOLD_LAST);
  assign w_exit         = w_own_release | w_own_drop | w_own_disabled | w_hold_limit;
  // A voluntary exit in the same cycle as the limit is not a revocation.
  assign w_timeout      = w_hold_limit & ~(w_own_release | w_own_drop | w_own_disabled);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_gnt           <= '0;
      r_gnt_valid     <= 1'b0;
      r_gnt_id        <= '0;
      r_last_id       <= LAST_ID_RESET;
      r_hold_cnt      <= '0;
      r_timeout_pulse <= 1'b0;
      r_timeout_cnt   <= '0;
    end else begin
      r_timeout_pulse <= 1'b0;
      unique case (r_state)
        IDLE, GAP: begin
          if (w_found) begin
            r_state     <= GRANT;
            r_gnt       <= id_to_onehot(w_winner);
            r_gnt_valid <= 1'b1;
            r_gnt_id    <= w_winner;
            r_last_id   <= w_winner;
            r_hold_cnt  <= '0;
          end else begin
            r_state     <= IDLE;
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_state     <= GAP;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            if (w_timeout) begin
              r_timeout_pulse <= 1'b1;
              if (r_timeout_cnt != 8'hFF) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
              end
            end
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign gnt_valid     = r_gnt_valid;
  assign gnt_id        = r_gnt_id;
  assign timeout_pulse = r_timeout_pulse;
  assign timeout_cnt   = r_timeout_cnt;

endmodule

// File: tb/tb_five_way_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_five_way_rr_scheduler
//   Directed bench for five_way_rr_scheduler built with MAX_HOLD=4.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_five_way_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] release_i;
  logic [4:0] en_mask;
  logic [4:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout_pulse;
  logic [7:0] timeout_cnt;

  int n_cmp = 0;
  int n_err = 0;

  five_way_rr_scheduler #(.MAX_HOLD(4), .NUM_REQ(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .release_i     (release_i),
    .en_mask       (en_mask),
    .gnt           (gnt),
    .gnt_valid     (gnt_valid),
    .gnt_id        (gnt_id),
    .timeout_pulse (timeout_pulse),
    .timeout_cnt   (timeout_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [4:0] g, input logic [2:0] id);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(|g));
    check({tag, ".id"}, 32'(gnt_id), 32'(id));
  endtask

  int order [5] = '{1, 2, 3, 4, 0};

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    release_i = '0;
    en_mask   = 5'b11111;
    repeat (2) @(posedge clk);
    #1;
    check_grant("reset", 5'b00000, 3'd0);
    check("reset.pulse", 32'(timeout_pulse), 32'd0);
    check("reset.cnt", 32'(timeout_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two requesters: first winner from index 0, then 4 after one gap.
    req = 5'b10001;
    tick();
    check_grant("rr0", 5'b00001, 3'd0);
    release_i = 5'b00001;
    tick();
    release_i = '0;
    check_grant("rr0.gap", 5'b00000, 3'd0);
    tick();
    check_grant("rr4", 5'b10000, 3'd4);
    req = '0;
    tick();
    check_grant("rr4.gap", 5'b00000, 3'd4);
    tick();

    // All five requesting, one-cycle tenures: order 0,1,2,3,4,0.
    req = 5'b11111;
    tick();
    check_grant("all.first", 5'b00001, 3'd0);
    for (int i = 0; i < 5; i++) begin
      release_i = gnt;
      tick();
      release_i = '0;
      check("all.gap", 32'(gnt), 32'd0);
      tick();
      check_grant($sformatf("all.%0d", i), 5'b00001 << order[i], 3'(order[i]));
    end
    req = '0;
    tick();
    tick();

    // Timeout: requester 2 never releases, MAX_HOLD=4.
    req = 5'b00100;
    tick();
    check_grant("to.c1", 5'b00100, 3'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to.held", 32'(gnt), 32'b00100);
    end
    tick();
    check("to.gap.gnt", 32'(gnt), 32'd0);
    check("to.pulse", 32'(timeout_pulse), 32'd1);
    check("to.cnt1", 32'(timeout_cnt), 32'd1);
    tick();
    check("to.regrant", 32'(gnt), 32'b00100);
    check("to.pulse.off", 32'(timeout_pulse), 32'd0);

    // Release coincides with the hold limit: release wins.
    repeat (3) tick();
    release_i = 5'b00100;
    tick();
    release_i = '0;
    check("relto.gnt", 32'(gnt), 32'd0);
    check("relto.pulse", 32'(timeout_pulse), 32'd0);
    check("relto.cnt", 32'(timeout_cnt), 32'd1);
    tick();
    check("relto.regrant", 32'(gnt), 32'b00100);

    // Repeated timeouts saturate the counter.
    for (int i = 0; i < 300; i++) begin
      repeat (5) tick();
      if (i == 99) check("sat.cnt101", 32'(timeout_cnt), 32'd101);
    end
    check("sat.cnt255", 32'(timeout_cnt), 32'd255);
    req = '0;
    tick();
    tick();

    // Masked requester is never granted; dropping the owner's mask ends it.
    en_mask = 5'b11011;
    req     = 5'b00100;
    tick();
    tick();
    check_grant("mask.none", 5'b00000, 3'd2);
    en_mask = 5'b11111;
    req     = 5'b00010;
    tick();
    check_grant("mask.g1", 5'b00010, 3'd1);
    tick();
    check("mask.held", 32'(gnt), 32'b00010);
    en_mask = 5'b11101;
    tick();
    check("mask.drop", 32'(gnt), 32'd0);
    en_mask = 5'b11111;
    req     = '0;
    tick();

    // Asynchronous reset mid-grant, then pointer restored to 4.
    req = 5'b00010;
    tick();
    check_grant("ar.g1", 5'b00010, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_grant("ar.async", 5'b00000, 3'd0);
    check("ar.pulse", 32'(timeout_pulse), 32'd0);
    check("ar.cnt", 32'(timeout_cnt), 32'd0);
    req = 5'b00011;
    #1;
    rst_n = 1'b1;
    tick();
    check_grant("ar.first", 5'b00001, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
